// File: rtl/ped_signal.sv
// Pedestrian crossing controller: services a latched button request at the
// onset of vehicle red with WALK, flashing DON'T WALK, then solid DON'T WALK.
module ped_signal #(
  parameter int unsigned WALK_CYC  = 20,
  parameter int unsigned FLASH_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_red,
  input  logic       i_yellow,
  input  logic       i_green,
  input  logic       i_btn,
  output logic       o_walk,
  output logic       o_dont_walk,
  output logic       o_wait,
  output logic [4:0] o_remain,
  output logic       o_abort
);

  typedef enum logic [1:0] {
    ST_DW    = 2'd0,
    ST_WALK  = 2'd1,
    ST_FLASH = 2'd2
  } state_t;

  localparam logic [4:0] WALK_LAST  = 5'(WALK_CYC - 1);
  localparam logic [4:0] FLASH_LAST = 5'(FLASH_CYC - 1);
  localparam logic [4:0] TOTAL_CYC  = 5'(WALK_CYC + FLASH_CYC);
  localparam logic [4:0] FLASH_LEN  = 5'(FLASH_CYC);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       req_q, req_d;
  logic       red_q, red_d;
  logic       abort_q, abort_d;

  logic red_ok;
  logic onset;

  assign red_ok = i_red & ~i_yellow & ~i_green;
  assign onset  = red_ok & ~red_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_DW;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      red_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      red_q   <= red_d;
      abort_q <= abort_d;
    end
  end

  // Loss of a legal red has priority over normal WALK/FLASH sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    red_d   = red_ok;
    abort_d = 1'b0;
    unique case (state_q)
      ST_DW: begin
        cnt_d = '0;
        if (onset && (req_q || i_btn)) begin
          state_d = ST_WALK;
          req_d   = 1'b0;
        end else begin
          req_d = req_q | i_btn;
        end
      end
      ST_WALK: begin
        req_d = 1'b0;
        if (!red_ok) begin
          state_d = ST_DW;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (cnt_q == WALK_LAST) begin
          state_d = ST_FLASH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_FLASH: begin
        req_d = 1'b0;
        if (!red_ok) begin
          state_d = ST_DW;
          cnt_d   = '0;
          abort_d = 1'b1;
        end else if (cnt_q == FLASH_LAST) begin
          state_d = ST_DW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = ST_DW;
        cnt_d   = '0;
        req_d   = 1'b0;
      end
    endcase
  end

  // Outputs depend only on registered state.
  always_comb begin
    o_walk      = 1'b0;
    o_dont_walk = 1'b1;
    o_remain    = '0;
    unique case (state_q)
      ST_WALK: begin
        o_walk      = 1'b1;
        o_dont_walk = 1'b0;
        o_remain    = TOTAL_CYC - cnt_q;
      end
      ST_FLASH: begin
        o_dont_walk = cnt_q[1];
        o_remain    = FLASH_LEN - cnt_q;
      end
      default: ;
    endcase
  end

  assign o_wait  = req_q;
  assign o_abort = abort_q;

endmodule

// File: tb/tb_ped_signal.sv
// Scoreboard bench for ped_signal: stimulus pushes per-cycle expectations from
// an elapsed-time model; a negedge monitor pops and compares them.
module tb_ped_signal;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_red, i_yellow, i_green, i_btn;
  logic       o_walk, o_dont_walk, o_wait, o_abort;
  logic [4:0] o_remain;

  ped_signal #(.WALK_CYC(20), .FLASH_CYC(8)) dut (
    .clk(clk), .rst(rst), .i_red(i_red), .i_yellow(i_yellow), .i_green(i_green),
    .i_btn(i_btn), .o_walk(o_walk), .o_dont_walk(o_dont_walk), .o_wait(o_wait),
    .o_remain(o_remain), .o_abort(o_abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       walk;
    logic       dw;
    logic       wt;
    logic [4:0] remain;
    logic       abort;
  } outs_t;

  outs_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Model: age = cycles since WALK became visible, -1 when not in service.
  int m_age;
  bit m_req, m_red_prev, m_abort;

  function automatic outs_t model_out();
    outs_t e;
    e.wt    = m_req;
    e.abort = m_abort;
    if (m_age >= 0 && m_age < 20) begin
      e.walk = 1'b1; e.dw = 1'b0; e.remain = 5'(28 - m_age);
    end else if (m_age >= 20 && m_age < 28) begin
      e.walk = 1'b0; e.dw = 1'(((m_age - 20) >> 1) & 1); e.remain = 5'(28 - m_age);
    end else begin
      e.walk = 1'b0; e.dw = 1'b1; e.remain = 5'd0;
    end
    return e;
  endfunction

  function automatic void model_reset();
    m_age = -1; m_req = 0; m_red_prev = 0; m_abort = 0;
  endfunction

  function automatic void check(string name, outs_t act, outs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got walk=%b dw=%b wait=%b remain=%0d abort=%b, want walk=%b dw=%b wait=%b remain=%0d abort=%b",
               name, $time, act.walk, act.dw, act.wt, act.remain, act.abort,
               exp.walk, exp.dw, exp.wt, exp.remain, exp.abort);
    end
  endfunction

  function automatic outs_t dut_out();
    outs_t a;
    a.walk = o_walk; a.dw = o_dont_walk; a.wt = o_wait; a.remain = o_remain; a.abort = o_abort;
    return a;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) check("cycle", dut_out(), exp_q.pop_front());
  end

  task automatic step(bit r, bit y, bit g, bit b);
    bit red_ok, onset;
    i_red = r; i_yellow = y; i_green = g; i_btn = b;
    red_ok = r && !y && !g;
    onset  = red_ok && !m_red_prev;
    if (m_age < 0) begin
      m_abort = 0;
      if (onset && (m_req || b)) begin m_age = 0; m_req = 0; end
      else m_req = m_req | b;
    end else if (!red_ok) begin
      m_age = -1; m_abort = 1;
    end else begin
      m_abort = 0;
      m_age++;
      if (m_age == 28) m_age = -1;
    end
    m_red_prev = red_ok;
    @(posedge clk);
    exp_q.push_back(model_out());
    #1;
  endtask

  // n cycles of one lamp colour, with a single button press at index btn_at.
  task automatic run(int n, bit r, bit y, bit g, int btn_at);
    for (int i = 0; i < n; i++) step(r, y, g, i == btn_at);
  endtask

  task automatic traffic(int red_btn, int green_btn, int yel_btn);
    run(30, 1, 0, 0, red_btn);
    run(20, 0, 0, 1, green_btn);
    run(5,  0, 1, 0, yel_btn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, want completion by 200000");
    $fatal(1, "timeout");
  end

  initial begin
    outs_t rst_exp;
    rst_exp = '{walk: 1'b0, dw: 1'b1, wt: 1'b0, remain: 5'd0, abort: 1'b0};
    rst = 1'b1; i_red = 1'b1; i_yellow = 1'b0; i_green = 1'b0; i_btn = 1'b0;
    model_reset();
    #2 exp_q.push_back(rst_exp);
    @(negedge clk); #2 rst = 1'b0;

    // Idle traffic: no service.
    repeat (3) traffic(-1, -1, -1);
    // Press during green, serviced at next onset.
    traffic(-1, 3, -1);
    traffic(-1, -1, -1);
    // Press in the onset cycle of red.
    traffic(0, -1, -1);
    // Press at red cycle 5 with no request: waits for next red.
    traffic(5, -1, -1);
    // Press during WALK ignored; following red not serviced.
    traffic(5, -1, -1);
    traffic(-1, -1, -1);
    // Abort by green at WALK cycle 10.
    run(30, 1, 0, 0, -1); run(20, 0, 0, 1, 2); run(5, 0, 1, 0, -1);
    run(11, 1, 0, 0, -1); run(20, 0, 0, 1, -1); run(5, 0, 1, 0, -1);
    // Abort by illegal red+green at WALK cycle 10.
    run(11, 1, 0, 0, -1); run(20, 0, 0, 1, 4); run(5, 0, 1, 0, -1);
    run(11, 1, 0, 0, -1); step(1, 0, 1, 0); run(19, 0, 0, 1, -1); run(5, 0, 1, 0, -1);
    // Asynchronous reset mid-FLASH, checked before any clock edge.
    run(11, 1, 0, 0, -1); run(20, 0, 0, 1, 1); run(5, 0, 1, 0, -1);
    run(25, 1, 0, 0, -1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1 check("async_reset", dut_out(), rst_exp);
    model_reset();
    exp_q.push_back(rst_exp);
    @(negedge clk); #1 rst = 1'b0;
    // Post-reset: onset press serviced, then idle.
    traffic(0, -1, -1);
    traffic(-1, -1, -1);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ped_signal.md
# ped_signal

Pedestrian crossing controller that sits directly downstream of the vehicle traffic-light FSM and consumes its one-hot red/yellow/green lamp outputs. A latched push-button request is serviced only at the start of a vehicle-red phase. Servicing drives WALK, then flashing DON'T WALK, then solid DON'T WALK, all inside the 30-cycle vehicle red window. The block also exports a remaining-time countdown and aborts to DON'T WALK whenever vehicle red is lost or the lamp inputs are not one-hot.

## Interface
- WALK_CYC, 20, cycles of solid WALK per service
- FLASH_CYC, 8, cycles of flashing DON'T WALK per service; WALK_CYC+FLASH_CYC must be ≤ 30 and ≤ 31 (o_remain width)
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- i_red  in  1  vehicle red lamp from the traffic-light FSM
- i_yellow  in  1  vehicle yellow lamp
- i_green  in  1  vehicle green lamp
- i_btn  in  1  pedestrian button; synchronous to clk, level-sampled each cycle
- o_walk  out  1  WALK lamp
- o_dont_walk  out  1  DON'T WALK lamp (blinks during FLASH)
- o_wait  out  1  request-pending indicator ("WAIT" lamp)
- o_remain  out  5  cycles of crossing time remaining; 0 outside service
- o_abort  out  1  one-cycle pulse when a service is cut short

## Operation
- Inputs are legal only when exactly one of i_red, i_yellow, i_green is 1.
- red_ok = i_red & ~i_yellow & ~i_green.
- Registers:
  - state ∈ {DW, WALK, FLASH}
  - cnt (5 b)
  - req
  - red_q (previous red_ok)
  - abort_q
- onset = red_ok & ~red_q.
- req update:
  - In DW: req ← req | i_btn.
  - In WALK/FLASH: i_btn is ignored; req holds 0.
- DW → WALK when onset & (req | i_btn). On that edge: cnt ← 0, req ← 0.
  - A press in the onset cycle itself is serviced.
- DW with onset and no request: stay in DW.
  - A press later in the same red phase is latched and waits for the next red onset.
- WALK:
  - cnt increments each cycle.
  - At cnt == WALK_CYC-1, go to FLASH with cnt ← 0.
- FLASH:
  - cnt increments each cycle.
  - At cnt == FLASH_CYC-1, go to DW with cnt ← 0.
- Abort: in WALK or FLASH with red_ok == 0 (yellow/green, or illegal input):
  - next edge: state ← DW, cnt ← 0, abort_q ← 1 for exactly one cycle.
  - Abort takes priority over normal sequencing.
  - req stays 0.
- Outputs are decoded from registers only; no combinational path from inputs to outputs.
  - o_walk = (state == WALK)
  - o_dont_walk = 1 in DW, 0 in WALK, cnt[1] in FLASH (pattern 0,0,1,1,0,0,1,1 for FLASH_CYC=8)
  - o_wait = req
  - o_remain: WALK_CYC+FLASH_CYC-cnt in WALK; FLASH_CYC-cnt in FLASH; 0 in DW
  - o_abort = abort_q
- Arithmetic: cnt and o_remain are 5-bit unsigned; the parameter constraint guarantees no wrap.

## Timing
- Reset values:
  - state=DW, cnt=0, req=0, red_q=0, abort_q=0
  - Output values in reset: o_walk=0, o_dont_walk=1, o_wait=0, o_remain=0, o_abort=0
- Reset mid-service returns to DW immediately (asynchronous) and drops any pending request.
- The traffic FSM resets into red, so an onset occurs on the first edge after reset. req=0 then, so no service unless i_btn=1 in that cycle.
- Service latency: WALK is visible 1 cycle after the onset cycle.
- WALK lasts exactly WALK_CYC cycles; FLASH lasts exactly FLASH_CYC cycles.
- The DW return occurs 28 cycles after entry (defaults), within the 30-cycle red window.
- o_wait rises 1 cycle after the press and falls on the WALK entry edge.
- Abort latency: DW and o_abort both appear 1 cycle after the cycle in which red_ok=0 is sampled.

## Test plan
- Reset, no button, 3 full traffic cycles → o_dont_walk=1, o_walk=0 and o_remain=0 throughout.
- Press during green (1 cycle) →
  - o_wait=1 next cycle.
  - At red onset+1: o_walk=1, o_remain=28, o_wait=0.
  - After 20 cycles: FLASH with o_remain=8 and o_dont_walk pattern 0,0,1,1,0,0,1,1.
  - Then DW, 2 cycles before the red phase ends.
- Press in the exact onset cycle → serviced in this red.
- Press at red cycle 5 with no prior request → not serviced now; o_wait held; serviced at the next red onset.
- Press during WALK → ignored: o_wait stays 0, and no service in the following red.
- Force i_green=1 (red=0) at WALK cycle 10 → next cycle: o_walk=0, o_dont_walk=1, o_remain=0, o_abort=1 for one cycle.
- Repeat the abort stimulus with illegal i_red=i_green=1 → same abort behaviour.
- Assert rst mid-FLASH → all outputs return to reset values immediately.
